keypad_encoder: RTL and testbench

Front-end for the calculator CPU's command input. Scans a 4x4 key matrix, debounces it, turns each key press into a command code and queues it in a small FIFO. Presents queued commands on `in_cmd` and holds each one until the CPU acknowledges it on `in_ack`. This block is the producer side of the CPU input handshake.

---
 rtl/keypad_encoder.sv | 141 ++++++++++++++
 tb/tb_keypad_encoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// keypad_encoder: scans and debounces a 4x4 key matrix, queues one command per press and hands it to the CPU.
// Define KEYPAD_REPEAT_EN to build the auto-repeat feature (adds REPEAT_DELAY/REPEAT_RATE parameters).
module keypad_encoder #(
  parameter int IC_N = 5,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int FIFO_DEPTH = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 60,
  parameter int REPEAT_RATE = 12
`endif
) (
  input  logic            Clock,
  input  logic            Reset,
  output logic [3:0]      row,
  input  logic [3:0]      col,
  input  logic            in_ack,
  output logic [IC_N-1:0] in_cmd,
  output logic            overflow
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, PRESENT} state_t;
  logic [3:0] sync1_q, sync2_q;
  logic [SW-1:0] slot_q;
  logic [1:0] idx_q;
  logic [15:0] snap_q, snap_d, prev_q, deb_q, deb_d;
  logic [3:0] stab_q, stab_d;
  logic [3:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] cmd_q, cmd_d;
  state_t state_q, state_d;
  logic ovf_q;
  logic slot_end, frame_end, onehot, press, push, pop, full, accept, load;
  logic [3:0] key;
  assign row = ~(4'b0001 << idx_q);
  assign in_cmd = IC_N'(cmd_q);
  assign overflow = ovf_q;
  // The last row sample of a frame is merged before comparing, so snap_d is the complete frame.
  always_comb begin
    slot_end = slot_q == SW'(SCAN_DIV - 1);
    frame_end = slot_end && idx_q == 2'd3;
    snap_d = snap_q;
    if (slot_end) snap_d[{idx_q, 2'b00} +: 4] = ~sync2_q;
    stab_d = stab_q;
    deb_d = deb_q;
    if (frame_end) begin
      stab_d = snap_d != prev_q ? 4'd0 : stab_q == 4'(DEBOUNCE) ? stab_q : stab_q + 4'd1;
      deb_d = stab_d == 4'(DEBOUNCE) ? snap_d : deb_q;
    end
    onehot = deb_d != '0 && (deb_d & (deb_d - 16'd1)) == '0;
    press = deb_q == '0 && onehot;
    key = '0;
    for (int i = 0; i < 16; i++) key = deb_d[i] ? 4'(i) : key;
  end
`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rep_q, rep_d;
  logic armed_q, armed_d, first_q, first_d, rep_fire;
  // Only a genuine press arms repeat, so a key left over from a multi-key chord never repeats.
  always_comb begin
    rep_d = rep_q;
    armed_d = armed_q;
    first_d = first_q;
    rep_fire = 1'b0;
    if (deb_d != deb_q) begin
      rep_d = '0;
      armed_d = press;
      first_d = 1'b1;
    end else if (frame_end && armed_q) begin
      rep_fire = rep_q + RW'(1) == RW'(first_q ? REPEAT_DELAY : REPEAT_RATE);
      rep_d = rep_fire ? '0 : rep_q + RW'(1);
      first_d = first_q && !rep_fire;
    end
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      rep_q <= '0;
      armed_q <= 1'b0;
      first_q <= 1'b1;
    end else begin
      rep_q <= rep_d;
      armed_q <= armed_d;
      first_q <= first_d;
    end
  end
  assign push = press || rep_fire;
`else
  assign push = press;
`endif
  // Pop is applied before push, so a full FIFO still accepts a push in the cycle it is acked.
  always_comb begin
    pop = state_q == PRESENT && in_ack;
    full = cnt_q == CW'(FIFO_DEPTH);
    accept = push && (!full || pop);
    cnt_d = cnt_q + CW'(accept) - CW'(pop);
    load = state_q == IDLE && cnt_q != '0;
    state_d = load ? PRESENT : pop ? IDLE : state_q;
    cmd_d = load ? {1'b1, mem_q[rp_q]} : pop ? 5'd0 : cmd_q;
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      slot_q <= '0;
      idx_q <= '0;
      snap_q <= '0;
      prev_q <= '0;
      stab_q <= '0;
      deb_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      state_q <= IDLE;
      cmd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sync1_q <= col;
      sync2_q <= sync1_q;
      slot_q <= slot_end ? '0 : slot_q + SW'(1);
      idx_q <= slot_end ? idx_q + 2'd1 : idx_q;
      snap_q <= snap_d;
      prev_q <= frame_end ? snap_d : prev_q;
      stab_q <= stab_d;
      deb_q <= deb_d;
      wp_q <= accept ? wp_q + AW'(1) : wp_q;
      rp_q <= pop ? rp_q + AW'(1) : rp_q;
      cnt_q <= cnt_d;
      state_q <= state_d;
      cmd_q <= cmd_d;
      ovf_q <= ovf_q || (push && !accept);
    end
  end
  always_ff @(posedge Clock) begin
    if (accept) mem_q[wp_q] <= key;
  end
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: randomized self-checking bench for keypad_encoder against a press-level key-matrix model.
`timescale 1ns/1ps
module tb_keypad_encoder;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int FRAME = 4 * SCAN_DIV;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] row, col;
  logic in_ack = 1'b0;
  logic [4:0] in_cmd;
  logic overflow;
  logic [15:0] keys = '0;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys[4*r+c]) col[c] = 1'b0;
  end
  keypad_encoder #(
    .IC_N(5), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(DEPTH)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_DELAY(3), .REPEAT_RATE(2)
`endif
  ) dut (
    .Clock(clk), .Reset(rst_n), .row(row), .col(col),
    .in_ack(in_ack), .in_cmd(in_cmd), .overflow(overflow)
  );

  function automatic logic [4:0] code_of(input int k);
    return {1'b1, 4'(k)};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cmd(input int budget, output logic [4:0] code, output int waited);
    waited = 0;
    while (waited < budget && in_cmd == 5'd0) begin
      @(negedge clk);
      waited++;
    end
    code = in_cmd;
  endtask

  task automatic count_busy(input int n, output int busy);
    busy = 0;
    repeat (n) begin
      @(negedge clk);
      if (in_cmd != 5'd0) busy++;
    end
  endtask

  task automatic settle();
    keys = '0;
    in_ack = 1'b1;
    cycles(6 * FRAME);
    in_ack = 1'b0;
    cycles(2);
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    rst_n = 1'b0;
    keys = '0;
    in_ack = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    n_checks++; if (row !== 4'b1110) begin n_fail++; $display("FAIL reset_row: got %b expected 1110", row); end
    n_checks++; if (in_cmd !== 5'd0) begin n_fail++; $display("FAIL reset_cmd: got %b expected 00000", in_cmd); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      exp_row = i < SCAN_DIV ? 4'b1110 : 4'b1101;
      n_checks++;
      if (row !== exp_row) begin n_fail++; $display("FAIL reset_scan[%0d]: got %b expected %b", i, row, exp_row); end
    end
  endtask

  task automatic test_single_press();
    logic [4:0] code;
    int w, bad;
    keys = 16'd1 << 9;
    wait_cmd(6 * FRAME, code, w);
    n_checks++; if (code !== code_of(9)) begin n_fail++; $display("FAIL single_code: got %b expected %b", code, code_of(9)); end
    n_checks++;
    if (w < DEBOUNCE * FRAME || w > (DEBOUNCE + 2) * FRAME + 4) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles expected %0d..%0d", w, DEBOUNCE * FRAME, (DEBOUNCE + 2) * FRAME + 4);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (in_cmd !== code) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL single_hold: got %0d unstable cycles expected 0", bad); end
    in_ack = 1'b1;
    @(negedge clk);
    in_ack = 1'b0;
    n_checks++; if (in_cmd !== 5'd0) begin n_fail++; $display("FAIL single_ack: got %b expected 00000", in_cmd); end
`ifndef KEYPAD_REPEAT_EN
    count_busy(6 * FRAME, bad);
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL single_once: got %0d busy cycles expected 0", bad); end
`endif
    settle();
  endtask

  task automatic test_bounce();
    logic [4:0] code;
    int w, bad, busy;
    bad = 0;
    for (int f = 0; f < 3; f++) begin
      keys = f == 1 ? 16'd0 : 16'd1;
      count_busy(FRAME, busy);
      bad += busy;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bounce_quiet: got %0d busy cycles expected 0", bad); end
    wait_cmd(6 * FRAME, code, w);
    n_checks++; if (code !== 5'b10000) begin n_fail++; $display("FAIL bounce_code: got %b expected 10000", code); end
    in_ack = 1'b1;
    @(negedge clk);
    in_ack = 1'b0;
`ifndef KEYPAD_REPEAT_EN
    count_busy(5 * FRAME, bad);
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bounce_once: got %0d busy cycles expected 0", bad); end
`endif
    settle();
  endtask

  task automatic test_multi_key();
    logic [4:0] code;
    int w, bad, busy;
    keys = (16'd1 << 1) | (16'd1 << 5);
    count_busy(5 * FRAME, bad);
    keys = 16'd1 << 1;
    count_busy(5 * FRAME, busy);
    bad += busy;
    keys = '0;
    count_busy(5 * FRAME, busy);
    bad += busy;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL multi_none: got %0d busy cycles expected 0", bad); end
    keys = 16'd1 << 13;
    wait_cmd(6 * FRAME, code, w);
    n_checks++; if (code !== 5'b11101) begin n_fail++; $display("FAIL multi_after: got %b expected 11101", code); end
    settle();
  endtask

  task automatic test_overflow();
    logic [4:0] exp_q [$];
    logic [4:0] code;
    logic model_ovf;
    int start, step, k, w, bad;
    exp_q = {};
    model_ovf = 1'b0;
    in_ack = 1'b0;
    start = $urandom_range(0, 15);
    step = 2 * $urandom_range(0, 7) + 1;
    for (int i = 0; i < 6; i++) begin
      k = (start + step * i) % 16;
      keys = 16'd1 << k;
      cycles(5 * FRAME);
      keys = '0;
      cycles(5 * FRAME);
      if (exp_q.size() < DEPTH) exp_q.push_back(code_of(k)); else model_ovf = 1'b1;
      n_checks++;
      if (overflow !== model_ovf) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, overflow, model_ovf); end
    end
    n_checks++; if (in_cmd !== exp_q[0]) begin n_fail++; $display("FAIL ovf_head: got %b expected %b", in_cmd, exp_q[0]); end
    in_ack = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      wait_cmd(8, code, w);
      n_checks++; if (code !== exp_q[j]) begin n_fail++; $display("FAIL ovf_order[%0d]: got %b expected %b", j, code, exp_q[j]); end
      n_checks++; if (w != (j == 0 ? 0 : 1)) begin n_fail++; $display("FAIL ovf_rate[%0d]: got %0d idle cycles expected %0d", j, w, j == 0 ? 0 : 1); end
      @(negedge clk);
      n_checks++; if (in_cmd !== 5'd0) begin n_fail++; $display("FAIL ovf_gap[%0d]: got %b expected 00000", j, in_cmd); end
    end
    count_busy(3 * FRAME, bad);
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ovf_dropped: got %0d busy cycles expected 0", bad); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    settle();
  endtask

  task automatic test_random();
    logic [4:0] code, exp_code;
    int mode, k, k2, ackd, w, bad, busy;
    for (int it = 0; it < 8; it++) begin
      mode = $urandom_range(0, 2);
      k = $urandom_range(0, 15);
      k2 = (k + $urandom_range(1, 15)) % 16;
      ackd = $urandom_range(0, 6);
      if (mode == 1) begin
        keys = (16'd1 << k) | (16'd1 << k2);
        count_busy(6 * FRAME, bad);
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand_none[%0d]: got %0d busy cycles expected 0", it, bad); end
      end else begin
        exp_code = code_of(k);
        if (mode == 2) begin
          keys = 16'd1 << k;
          cycles(FRAME);
          keys = '0;
          cycles(FRAME);
        end
        keys = 16'd1 << k;
        wait_cmd(8 * FRAME, code, w);
        n_checks++; if (code !== exp_code) begin n_fail++; $display("FAIL rand_code[%0d]: got %b expected %b", it, code, exp_code); end
        bad = 0;
        repeat (ackd) begin
          @(negedge clk);
          if (in_cmd !== exp_code) bad++;
        end
        in_ack = 1'b1;
        @(negedge clk);
        in_ack = 1'b0;
        if (in_cmd !== 5'd0) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand_handshake[%0d]: got %0d bad cycles expected 0", it, bad); end
      end
      keys = '0;
      count_busy(5 * FRAME, busy);
      n_checks++; if (busy != 0) begin n_fail++; $display("FAIL rand_release[%0d]: got %0d busy cycles expected 0", it, busy); end
    end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    logic [4:0] code;
    int w, t_prev, gap, exp_gap;
    in_ack = 1'b1;
    keys = 16'd1 << 3;
    t_prev = 0;
    for (int j = 0; j < 5; j++) begin
      wait_cmd(6 * FRAME, code, w);
      n_checks++; if (code !== 5'b10011) begin n_fail++; $display("FAIL repeat_code[%0d]: got %b expected 10011", j, code); end
      if (j > 0) begin
        gap = cyc - t_prev;
        exp_gap = (j == 1 ? 3 : 2) * FRAME;
        n_checks++; if (gap != exp_gap) begin n_fail++; $display("FAIL repeat_gap[%0d]: got %0d cycles expected %0d", j, gap, exp_gap); end
      end
      t_prev = cyc;
      @(negedge clk);
    end
    settle();
  endtask
`endif

  task automatic test_reset_mid();
    int bad;
    in_ack = 1'b0;
    keys = 16'd1 << 6;
    cycles(5 * FRAME);
    keys = '0;
    cycles(5 * FRAME);
    keys = 16'd1 << 7;
    cycles(5 * FRAME);
    keys = '0;
    cycles(FRAME);
    n_checks++; if (in_cmd !== code_of(6)) begin n_fail++; $display("FAIL mid_present: got %b expected %b", in_cmd, code_of(6)); end
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    n_checks++; if (in_cmd !== 5'd0) begin n_fail++; $display("FAIL mid_cmd: got %b expected 00000", in_cmd); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b expected 0", overflow); end
    n_checks++; if (row !== 4'b1110) begin n_fail++; $display("FAIL mid_row: got %b expected 1110", row); end
    in_ack = 1'b1;
    count_busy(6 * FRAME, bad);
    in_ack = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_discard: got %0d busy cycles expected 0", bad); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`else
    test_overflow();
    test_random();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
